vend_change_ctrl: RTL

Downstream vending/change controller fed by the coin credit accumulator. When that stage reports credit ≥ price, this block latches credit and price, drives the item dispenser through a request/acknowledge handshake, then pays out change one coin at a time (5000/2000/1000, greedy) through the coin hopper. Finally it requests that the accumulator's coin counters be cleared. A cancel input refunds the full credit without vending.

---
 rtl/vend_change_ctrl.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/vend_change_ctrl.sv
// Vending/change controller: latches credit and price from the coin accumulator,
// dispenses the item, pays change greedily (5000/2000/1000), then clears the credit.
module vend_change_ctrl (
    input  logic        clock,
    input  logic        reset,
    input  logic        credit_ok,
    input  logic [18:0] count_m,
    input  logic [8:0]  c_1000,
    input  logic [7:0]  c_2000,
    input  logic [6:0]  c_5000,
    input  logic        cancel,
    input  logic        item_done,
    input  logic        hopper_ack,
    output logic        vend,
    output logic        coin_req,
    output logic [1:0]  coin_sel,
    output logic        clear_credit,
    output logic        busy,
    output logic [20:0] change_left,
    output logic        short_change,
    output logic [2:0]  dbg_state
);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_CALC     = 3'd1,
        S_VEND     = 3'd2,
        S_PAY      = 3'd3,
        S_WAIT_ACK = 3'd4,
        S_CLEAR    = 3'd5
    } state_t;

    localparam logic [1:0] SEL_NONE = 2'b00;
    localparam logic [1:0] SEL_1000 = 2'b01;
    localparam logic [1:0] SEL_2000 = 2'b10;
    localparam logic [1:0] SEL_5000 = 2'b11;

    state_t      state_q, state_d;
    logic [20:0] credit_q, credit_d;
    logic [20:0] price_q, price_d;
    logic [20:0] change_q, change_d;
    logic [1:0]  sel_q, sel_d;
    logic        short_q, short_d;
    logic        vend_q, coin_req_q, clear_q, busy_q;
    logic [20:0] credit_in;
    logic [20:0] sel_value;

    // Worst case 1,656,000 still fits in 21 bits, so no term overflows.
    assign credit_in = 21'(c_1000) * 21'd1000
                     + 21'(c_2000) * 21'd2000
                     + 21'(c_5000) * 21'd5000;

    always_comb begin
        sel_value = '0;
        case (sel_q)
            SEL_1000: sel_value = 21'd1000;
            SEL_2000: sel_value = 21'd2000;
            SEL_5000: sel_value = 21'd5000;
            default:  sel_value = '0;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        credit_d = credit_q;
        price_d  = price_q;
        change_d = change_q;
        sel_d    = sel_q;
        short_d  = short_q;
        case (state_q)
            S_IDLE: begin
                // A refund wins over a pending vend.
                if (cancel && (credit_in != '0)) begin
                    credit_d = credit_in;
                    price_d  = '0;
                    change_d = credit_in;
                    short_d  = 1'b0;
                    state_d  = S_PAY;
                end else if (credit_ok) begin
                    credit_d = credit_in;
                    price_d  = {2'b00, count_m};
                    short_d  = 1'b0;
                    state_d  = S_CALC;
                end
            end
            S_CALC: begin
                if (credit_q < price_q) begin
                    state_d = S_IDLE;
                end else begin
                    change_d = credit_q - price_q;
                    state_d  = S_VEND;
                end
            end
            S_VEND: begin
                if (item_done) state_d = S_PAY;
            end
            S_PAY: begin
                if (change_q >= 21'd5000) begin
                    sel_d   = SEL_5000;
                    state_d = S_WAIT_ACK;
                end else if (change_q >= 21'd2000) begin
                    sel_d   = SEL_2000;
                    state_d = S_WAIT_ACK;
                end else if (change_q >= 21'd1000) begin
                    sel_d   = SEL_1000;
                    state_d = S_WAIT_ACK;
                end else begin
                    // Sub-1000 remainder cannot be paid; leave it visible.
                    if (change_q != '0) short_d = 1'b1;
                    state_d = S_CLEAR;
                end
            end
            S_WAIT_ACK: begin
                if (hopper_ack) begin
                    change_d = change_q - sel_value;
                    sel_d    = SEL_NONE;
                    state_d  = S_PAY;
                end
            end
            S_CLEAR: begin
                if (!credit_ok) begin
                    change_d = '0;
                    state_d  = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            credit_q   <= '0;
            price_q    <= '0;
            change_q   <= '0;
            sel_q      <= SEL_NONE;
            short_q    <= 1'b0;
            vend_q     <= 1'b0;
            coin_req_q <= 1'b0;
            clear_q    <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            credit_q   <= credit_d;
            price_q    <= price_d;
            change_q   <= change_d;
            sel_q      <= sel_d;
            short_q    <= short_d;
            // Level outputs are registered copies of the next-state decode.
            vend_q     <= (state_d == S_VEND);
            coin_req_q <= (state_d == S_WAIT_ACK);
            clear_q    <= (state_d == S_CLEAR);
            busy_q     <= (state_d != S_IDLE);
        end
    end

    assign vend         = vend_q;
    assign coin_req     = coin_req_q;
    assign coin_sel     = sel_q;
    assign clear_credit = clear_q;
    assign busy         = busy_q;
    assign change_left  = change_q;
    assign short_change = short_q;
    assign dbg_state    = state_q;

endmodule
